// File: rtl/store_buffer.sv
// In-order store buffer with a 1-cycle push-to-memory latency; st_ready=!full, mem_* held while mem_ready=0.
// Optional store-to-load forwarding is built when STORE_BUF_FWD_EN is defined.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_data,
  input  logic [3:0]               st_mask,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_wstrb,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  input  logic [31:0]              ld_addr,
  output logic [31:0]              fwd_data,
  output logic [3:0]               fwd_mask
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [29:0]   r_addr [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [3:0]    r_mask [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_push;
  logic w_pop;
  logic w_unused;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(DEPTH));
  assign count     = r_count;
  assign st_ready  = !full;
  assign mem_valid = !empty;
  assign mem_addr  = {r_addr[r_rd_ptr], 2'b00};
  assign mem_wdata = r_data[r_rd_ptr];
  assign mem_wstrb = r_mask[r_rd_ptr];

  // An all-zero mask completes the handshake but writes nothing, so it is never queued.
  assign w_push = st_valid && st_ready && (st_mask != 4'b0000);
  assign w_pop  = mem_valid && mem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
        r_mask[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_addr[r_wr_ptr] <= st_addr[31:2];
        r_data[r_wr_ptr] <= st_data;
        r_mask[r_wr_ptr] <= st_mask;
        r_wr_ptr         <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

`ifdef STORE_BUF_FWD_EN
  logic [PW-1:0] w_idx;

  // Walk oldest to newest so younger matching stores overwrite older lanes.
  always_comb begin
    fwd_data = '0;
    fwd_mask = '0;
    w_idx    = r_rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_rd_ptr + PW'(i);
      if ((CW'(i) < r_count) && (r_addr[w_idx] == ld_addr[31:2])) begin
        fwd_mask = fwd_mask | r_mask[w_idx];
        for (int b = 0; b < 4; b++) begin
          if (r_mask[w_idx][b]) begin
            fwd_data[8*b +: 8] = r_data[w_idx][8*b +: 8];
          end
        end
      end
    end
  end

  assign w_unused = ^{st_addr[1:0], ld_addr[1:0]};
`else
  assign fwd_data = '0;
  assign fwd_mask = '0;
  assign w_unused = ^{st_addr[1:0], ld_addr};
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: queue-based reference model checked every cycle, plus directed literal scenarios.
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_mask;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [2:0]  count;
  logic        empty;
  logic        full;
  logic [31:0] ld_addr;
  logic [31:0] fwd_data;
  logic [3:0]  fwd_mask;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data), .st_mask(st_mask),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .count(count), .empty(empty), .full(full),
    .ld_addr(ld_addr), .fwd_data(fwd_data), .fwd_mask(fwd_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } ent_t;

  ent_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Each lane comes from the youngest queued store to the same word that enables it.
  function automatic void model_fwd(output logic [31:0] d, output logic [3:0] m);
    d = 32'h0;
    m = 4'h0;
`ifdef STORE_BUF_FWD_EN
    for (int lane = 0; lane < 4; lane++) begin
      for (int k = q.size() - 1; k >= 0; k--) begin
        if (q[k].a[31:2] == ld_addr[31:2] && q[k].m[lane]) begin
          m[lane] = 1'b1;
          d[8*lane +: 8] = q[k].d[8*lane +: 8];
          break;
        end
      end
    end
`endif
  endfunction

  always @(negedge clk) begin
    logic [31:0] ed;
    logic [3:0]  em;
    logic        push;
    logic        pop;
    if (!reset) begin
      chk("count", {29'b0, count}, q.size());
      chk("empty", {31'b0, empty}, {31'b0, q.size() == 0});
      chk("full", {31'b0, full}, {31'b0, q.size() == DEPTH});
      chk("st_ready", {31'b0, st_ready}, {31'b0, q.size() != DEPTH});
      chk("mem_valid", {31'b0, mem_valid}, {31'b0, q.size() != 0});
      if (q.size() != 0) begin
        chk("mem_addr", mem_addr, q[0].a);
        chk("mem_wdata", mem_wdata, q[0].d);
        chk("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, q[0].m});
      end
      model_fwd(ed, em);
      chk("fwd_data", fwd_data, ed);
      chk("fwd_mask", {28'b0, fwd_mask}, {28'b0, em});
      pop  = (q.size() != 0) && mem_ready;
      push = st_valid && (q.size() != DEPTH) && (st_mask != 4'b0000);
      if (pop) void'(q.pop_front());
      if (push) q.push_back('{a: {st_addr[31:2], 2'b00}, d: st_data, m: st_mask});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_st(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    st_valid = v;
    st_addr  = a;
    st_data  = d;
    st_mask  = m;
  endtask

  initial begin
    reset = 1'b1;
    drive_st(1'b0, 32'h0, 32'h0, 4'h0);
    mem_ready = 1'b0;
    ld_addr   = 32'h0;
    #2;
    chk("rst_count", {29'b0, count}, 32'd0);
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_full", {31'b0, full}, 32'd0);
    chk("rst_st_ready", {31'b0, st_ready}, 32'd1);
    chk("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_fwd_mask", {28'b0, fwd_mask}, 32'h0);
    chk("rst_fwd_data", fwd_data, 32'h0);
    step();
    reset = 1'b0;

    // Single store reaches memory one cycle after the push.
    step();
    drive_st(1'b1, 32'h1002, 32'hABABABAB, 4'b0100);
    step();
    drive_st(1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    chk("single_mem_valid", {31'b0, mem_valid}, 32'd1);
    chk("single_mem_addr", mem_addr, 32'h1000);
    chk("single_wstrb", {28'b0, mem_wstrb}, 32'h4);
    chk("single_wdata", mem_wdata, 32'hABABABAB);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    #1;
    chk("single_drained", {31'b0, empty}, 32'd1);

    // Zero-mask store: handshake only.
    drive_st(1'b1, 32'h2000, 32'h12345678, 4'b0000);
    #1;
    chk("zmask_st_ready", {31'b0, st_ready}, 32'd1);
    step();
    drive_st(1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    chk("zmask_count", {29'b0, count}, 32'd0);
    chk("zmask_mem_valid", {31'b0, mem_valid}, 32'd0);

    // Fill to full, then a pop frees a slot only for the following cycle.
    for (int i = 0; i < 4; i++) begin
      drive_st(1'b1, 32'h3000 + 32'(i * 4), 32'hC0DE0000 + 32'(i), 4'hF);
      step();
    end
    drive_st(1'b1, 32'h3010, 32'hC0DE0004, 4'hF);
    #1;
    chk("fill_full", {31'b0, full}, 32'd1);
    chk("fill_st_ready", {31'b0, st_ready}, 32'd0);
    chk("fill_count", {29'b0, count}, 32'd4);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    #1;
    chk("fill_after_pop", {29'b0, count}, 32'd3);
    step();
    drive_st(1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    chk("fill_fifth_in", {29'b0, count}, 32'd4);
    chk("fill_head_addr", mem_addr, 32'h3004);

    // Backpressure: head holds for 5 stalled cycles.
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_stable_addr", mem_addr, 32'h3004);
      chk("bp_stable_data", mem_wdata, 32'hC0DE0001);
    end
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    mem_ready = 1'b0;
    #1;
    chk("bp_drained", {31'b0, empty}, 32'd1);

    // Forwarding.
    drive_st(1'b1, 32'h20, 32'h11111111, 4'b0011);
    step();
    drive_st(1'b1, 32'h22, 32'h22222222, 4'b1100);
    step();
    drive_st(1'b0, 32'h0, 32'h0, 4'h0);
    ld_addr = 32'h23;
    #1;
`ifdef STORE_BUF_FWD_EN
    chk("fwd_mask_2", {28'b0, fwd_mask}, 32'hF);
    chk("fwd_data_2", fwd_data, 32'h22221111);
`else
    chk("nofwd_mask", {28'b0, fwd_mask}, 32'h0);
    chk("nofwd_data", fwd_data, 32'h0);
`endif
    drive_st(1'b1, 32'h20, 32'h33333333, 4'b0001);
    step();
    drive_st(1'b0, 32'h0, 32'h0, 4'h0);
    #1;
`ifdef STORE_BUF_FWD_EN
    chk("fwd_data_3", fwd_data, 32'h22221133);
`else
    chk("nofwd_data_3", fwd_data, 32'h0);
`endif
    ld_addr = 32'h0;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    mem_ready = 1'b0;

    // Randomized traffic across pointer wrap, with forwarding lookups.
    for (int i = 0; i < 800; i++) begin
      drive_st(1'($urandom_range(0, 1)), 32'h100 + 32'($urandom_range(0, 15)), $urandom(),
               4'($urandom_range(0, 15)));
      mem_ready = ($urandom_range(0, 2) != 0);
      ld_addr   = 32'h100 + 32'($urandom_range(0, 15));
      step();
    end
    drive_st(1'b0, 32'h0, 32'h0, 4'h0);
    mem_ready = 1'b0;

    // Async reset mid-cycle with pending entries.
    for (int i = 0; i < 3; i++) begin
      drive_st(1'b1, 32'h4000 + 32'(i * 4), 32'h5A5A0000 + 32'(i), 4'hF);
      step();
    end
    drive_st(1'b0, 32'h0, 32'h0, 4'h0);
    #2;
    reset = 1'b1;
    q.delete();
    #1;
    chk("arst_count", {29'b0, count}, 32'd0);
    chk("arst_empty", {31'b0, empty}, 32'd1);
    chk("arst_mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("arst_mem_addr", mem_addr, 32'h0);
    chk("arst_mem_wdata", mem_wdata, 32'h0);
    chk("arst_mem_wstrb", {28'b0, mem_wstrb}, 32'h0);
    chk("arst_st_ready", {31'b0, st_ready}, 32'd1);
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
